// File: rtl/fir_block_sequencer_if.sv
// Datapath-side bundle between the block sequencer, the dataX/dataY buffers and the FIR filter.
interface fir_block_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] x_rd_addr;
    logic [DW-1:0] x_rd_data;
    logic [DW-1:0] fir_in;
    logic [DW-1:0] fir_out;
    logic          y_wr_en;
    logic [AW-1:0] y_wr_addr;
    logic [DW-1:0] y_wr_data;

    modport master (
        output x_rd_addr, fir_in, y_wr_en, y_wr_addr, y_wr_data,
        input  x_rd_data, fir_out
    );

    modport slave (
        input  x_rd_addr, fir_in, y_wr_en, y_wr_addr, y_wr_data,
        output x_rd_data, fir_out
    );
endinterface

// File: rtl/fir_block_sequencer.sv
// Runs one block of samples through the streaming FIR: zero-prime, feed the block from dataX,
// and land each filter result in dataY at the matching address after the filter latency.
//
// state   | meaning
// S_IDLE  | waiting for an accepted start edge
// S_PRIME | feeding zeros to flush filter tap history
// S_FEED  | streaming dataX[0..len-1] into the filter
// S_DRAIN | feeding zeros until every tagged sample has been written
// S_DONE  | one-cycle completion state
module fir_block_sequencer #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int PRIME_CYCLES = 16,
    parameter int LATENCY      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW:0]          len,
    fir_block_sequencer_if.master dp,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [AW:0]          sample_count
);
    localparam int PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES + 1) : 1;
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic          start_r;
    logic          edge_arm;
    logic [AW:0]   len_q;
    logic [AW:0]   feed_cnt;
    logic [PW-1:0] prime_cnt;
    logic [AW-1:0] rd_addr;
    logic [LATENCY-1:0] pipe_vld;
    logic [AW-1:0] pipe_addr [LATENCY];

    logic          start_edge;
    logic          in_run;
    logic          wr_en;
    logic [AW:0]   len_clamp;
    logic [LATENCY-1:0] pipe_shl;
    logic          pipe_empty_next;

    // edge_arm blocks a start that was already high when reset released
    assign start_edge      = start & ~start_r & edge_arm;
    assign in_run          = (state == S_PRIME) || (state == S_FEED) || (state == S_DRAIN);
    assign wr_en           = pipe_vld[LATENCY-1] & ~abort;
    assign len_clamp       = (len > MAX_LEN) ? MAX_LEN : len;
    assign pipe_shl        = pipe_vld << 1;
    assign pipe_empty_next = (pipe_shl == '0);

    assign dp.x_rd_addr = rd_addr;
    assign dp.fir_in    = (state == S_FEED) ? dp.x_rd_data : '0;
    assign dp.y_wr_en   = wr_en;
    assign dp.y_wr_addr = pipe_addr[LATENCY-1];
    assign dp.y_wr_data = dp.fir_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            start_r      <= 1'b0;
            edge_arm     <= 1'b0;
            len_q        <= '0;
            feed_cnt     <= '0;
            prime_cnt    <= '0;
            rd_addr      <= '0;
            pipe_vld     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            sample_count <= '0;
            for (int k = 0; k < LATENCY; k++) pipe_addr[k] <= '0;
        end else begin
            start_r  <= start;
            edge_arm <= 1'b1;

            pipe_vld[0]  <= (state == S_FEED);
            pipe_addr[0] <= rd_addr;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end

            if (wr_en) sample_count <= sample_count + 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    // len=0 runs reach S_DONE directly, so done is raised here as well
                    if (state == S_DONE) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                    if (start_edge && !abort) begin
                        done         <= 1'b0;
                        aborted      <= 1'b0;
                        sample_count <= '0;
                        len_q        <= len_clamp;
                        if (len_clamp == '0) begin
                            state <= S_DONE;
                        end else if (PRIME_CYCLES > 0) begin
                            state     <= S_PRIME;
                            prime_cnt <= PW'(PRIME_CYCLES);
                            busy      <= 1'b1;
                        end else begin
                            state    <= S_FEED;
                            feed_cnt <= len_clamp;
                            rd_addr  <= '0;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    if (prime_cnt == PW'(1)) begin
                        state    <= S_FEED;
                        feed_cnt <= len_q;
                        rd_addr  <= '0;
                    end else begin
                        prime_cnt <= prime_cnt - 1'b1;
                    end
                end
                S_FEED: begin
                    if (feed_cnt == (AW+1)'(1)) begin
                        state   <= S_DRAIN;
                        rd_addr <= '0;
                    end else begin
                        feed_cnt <= feed_cnt - 1'b1;
                        rd_addr  <= rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty_next) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (in_run && abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                aborted  <= 1'b1;
                done     <= 1'b0;
                rd_addr  <= '0;
                pipe_vld <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fir_block_sequencer.sv
// Directed bench for fir_block_sequencer: identity filter model, dataX memory, write scoreboard.
module tb_fir_block_sequencer;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PRIME = 16;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   sample_count;

    fir_block_sequencer_if #(.DW(DW), .AW(AW)) dp ();

    fir_block_sequencer #(
        .DW(DW), .AW(AW), .PRIME_CYCLES(PRIME), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .len(len),
        .dp(dp),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] xmem [32];
    assign dp.x_rd_data = xmem[dp.x_rd_addr];

    // identity filter: fir_out is fir_in delayed LAT cycles; can be preloaded with garbage
    logic          load_garbage;
    logic [DW-1:0] dl [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dl[k] <= load_garbage ? (32'hDEAD0000 + k) : dl[k-1];
        dl[0] <= load_garbage ? 32'h0BAD0BAD : dp.fir_in;
    end
    assign dp.fir_out = dl[LAT-1];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;
    wr_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit pd, pa;
    int pcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        wr_t w;
        @(negedge clk);
        if (dp.y_wr_en) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_write observed addr=%0d expected no write", dp.y_wr_addr);
            end
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk("wr_addr", 64'(dp.y_wr_addr), 64'(w.addr));
                chk("wr_data", 64'(dp.y_wr_data), 64'(w.data));
                chk("wr_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
    endtask

    task automatic do_run(input int ln, input int abort_at, input int repulse_at,
                          input int ncyc, input bit accept, input bit garbage);
        int le, nwr, lastb, ce;
        bit ab, be, fe, de, ae;
        le  = (ln > 32) ? 32 : ln;
        ab  = (abort_at >= 0);
        nwr = le;
        if (ab) nwr = ((abort_at - 25) < 0) ? 0 : (((abort_at - 25) > le) ? le : (abort_at - 25));
        if (!accept) nwr = 0;

        tick();
        start = 1'b1;
        len = 6'(ln);
        abort = !accept;
        load_garbage = garbage;
        for (int i = 0; i < nwr; i++) sb.push_back('{addr: AW'(i), data: xmem[i], cyc: cyc + 25 + i});
        sample();
        chk("c0_busy", 64'(busy), 64'(0));
        chk("c0_done", 64'(done), 64'(pd));
        chk("c0_aborted", 64'(aborted), 64'(pa));

        be = 0; fe = 0; de = pd; ae = pa; ce = pcnt;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start = (c == repulse_at);
            abort = (c == abort_at);
            load_garbage = 1'b0;
            if (c == 2) len = 6'd9;
            sample();
            if (accept) begin
                lastb = ab ? abort_at : 24 + le;
                be = (le > 0) && (c <= lastb);
                fe = (le > 0) && (c >= 17) && (c <= 16 + le) && (!ab || c <= abort_at);
                de = ab ? 1'b0 : (c >= ((le > 0) ? 25 + le : 2));
                ae = ab && (c > abort_at);
                ce = (c - 25 < 0) ? 0 : (c - 25);
                if (ce > nwr) ce = nwr;
            end
            chk("busy", 64'(busy), 64'(be));
            chk("x_rd_addr", 64'(dp.x_rd_addr), fe ? 64'(c - 17) : 64'(0));
            chk("fir_in", 64'(dp.fir_in), fe ? 64'(xmem[c-17]) : 64'(0));
            chk("done", 64'(done), 64'(de));
            chk("aborted", 64'(aborted), 64'(ae));
            chk("sample_count", 64'(sample_count), 64'(ce));
        end
        chk("sb_leftover", 64'(sb.size()), 64'(0));
        sb.delete();
        pd = de; pa = ae; pcnt = ce;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; len = '0; load_garbage = 1'b0;
        for (int i = 0; i < 32; i++) xmem[i] = $urandom() | 32'h1;
        tick(); tick();
        sample();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_aborted", 64'(aborted), 64'(0));
        chk("rst_count", 64'(sample_count), 64'(0));
        chk("rst_wr_en", 64'(dp.y_wr_en), 64'(0));
        chk("rst_rd_addr", 64'(dp.x_rd_addr), 64'(0));
        tick(); reset = 1'b1;
        tick(); tick();
        pd = 0; pa = 0; pcnt = 0;

        do_run(32, -1, -1, 60, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) xmem[i] = $urandom() | 32'h1;
        do_run(32, -1, -1, 60, 1'b1, 1'b1);
        do_run(0, -1, -1, 5, 1'b1, 1'b0);
        do_run(5, 28, -1, 35, 1'b1, 1'b0);
        do_run(32, -1, 10, 60, 1'b1, 1'b0);
        do_run(45, -1, -1, 60, 1'b1, 1'b0);
        do_run(4, -1, -1, 6, 1'b0, 1'b0);

        tick(); start = 1'b1; reset = 1'b0;
        tick(); tick();
        tick(); reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            sample();
            chk("held_start_busy", 64'(busy), 64'(0));
            chk("held_start_done", 64'(done), 64'(0));
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_block_sequencer.md
Name: fir_block_sequencer

Overview:
- Sequences one block of samples through the streaming FIR datapath.
- On a start edge it does three things in order:
  - feeds zeros to flush the filter's tap history;
  - streams len input-buffer words into the filter, one per cycle;
  - writes each filter output into the output buffer at the matching address, after the filter's fixed latency.
- It replaces ad-hoc free-running index counters between the bus register file, the dataX/dataY buffers and the filter.
- It provides busy, done and aborted status for the register map.

Parameters:
DW, 32, sample width
AW, 5, buffer address width; maximum block = 2**AW samples
PRIME_CYCLES, 16, zero samples fed before the block to clear filter history; 0 allowed (no priming)
LATENCY, 8, filter delay in cycles from a sample on fir_in to its result on fir_out; must be >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start  in  1  level from register file; only a 0->1 transition triggers a run
abort  in  1  level; when high, terminates any run
len  in  AW+1  block length, 0..2**AW; sampled on the accepted start; values >2**AW are treated as 2**AW
x_rd_addr  out  AW  input buffer read address
x_rd_data  in  DW  input buffer data, combinational read of x_rd_addr
fir_in  out  DW  sample to filter
fir_out  in  DW  filter result
y_wr_en  out  1  output buffer write strobe
y_wr_addr  out  AW  output buffer write address
y_wr_data  out  DW  output buffer write data (= fir_out)
busy  out  1  run in progress
done  out  1  last run completed normally; sticky
aborted  out  1  last run was aborted; sticky
sample_count  out  AW+1  number of output writes in the current or last run

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, all outputs 0, capture pipeline cleared, start-edge register cleared. A start held high through reset release does not trigger a run.
- Start edge: start=1 and start_r=0 in the same cycle.
- States and transitions:
  - IDLE -> PRIME on start edge, abort=0 and len!=0. If PRIME_CYCLES=0, go directly to FEED.
  - IDLE -> DONE_ST on start edge with len=0. No writes; done rises next cycle.
  - PRIME: PRIME_CYCLES cycles; fir_in=0; no writes are scheduled for these cycles.
  - FEED: len cycles; x_rd_addr = i for i = 0..len-1; fir_in = x_rd_data; sample i is tagged (valid, addr=i) into a LATENCY-deep shift register.
  - DRAIN: entered after the last FEED cycle; fir_in=0; stays until the shift register is empty.
  - DONE_ST: one cycle, then IDLE.
- Outputs per state:
  - fir_in=0 and x_rd_addr=0 outside FEED.
  - busy=1 in PRIME, FEED and DRAIN.
- Write timing: y_wr_en=1 exactly LATENCY cycles after the cycle in which sample i was on fir_in, with y_wr_addr=i and y_wr_data=fir_out that cycle.
- sample_count increments on each write.
- Write ordering: writes are strictly in address order, one per cycle, with no gaps.
- Done/aborted flags:
  - done goes to 1 in the cycle after the last write. It clears on the next accepted start.
  - aborted clears on the next accepted start.
- Start acceptance:
  - A start edge while busy is ignored; the edge is consumed and not queued.
- Abort:
  - abort=1 in any busy state -> IDLE next cycle.
  - The shift register is flushed, so no further y_wr_en is asserted.
  - busy=0, aborted=1, done=0. sample_count holds the writes completed so far.
  - abort in IDLE has no effect. A start edge coinciding with abort=1 is not accepted.
- Changing len while busy has no effect on the current run.
- Counters are sized AW+1, so len=2**AW runs 2**AW samples without wrap.
- y_wr_addr never exceeds len-1.

Test Plan:
- reset=0 for 2 cycles, then start edge sampled at cycle 0 with len=32, PRIME_CYCLES=16, LATENCY=8, and an identity filter model (fir_out = fir_in delayed 8) -> busy high cycles 1–56; x_rd_addr 0..31 in cycles 17–48; y_wr_en in cycles 25–56 with addr 0..31 and data equal to dataX; done=1 from cycle 57; sample_count=32.
- Same setup, but the filter is pre-loaded with nonzero garbage -> y writes carry no garbage, because PRIME flushes the history.
- len=0 start -> no y_wr_en; busy stays 0; done=1 at cycle 2.
- len=5 run; abort=1 at cycle 28 -> writes for addr 0..2 only (cycles 25–27); busy=0 and aborted=1 from cycle 29; done=0; sample_count=3.
- Start re-pulsed at cycle 10 of a len=32 run -> ignored: exactly 32 writes and a single done. A start edge after done -> done and aborted clear, and a new run begins.
- start held high through reset release -> no run. Start edge with abort=1 -> no run, all status unchanged.
